// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the fifo_reader block.
//   state_t   - drain-session FSM state encoding
//   BUF_DEPTH - number of words the output buffer can hold
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] BUF_DEPTH = 2'd2;

endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order word buffer with valid/ready on both sides.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   in_valid/in_ready  - upstream handshake, in_data captured on in_valid && in_ready
//   in_data            - upstream word
//   out_valid/out_ready- downstream handshake, out_data popped on out_valid && out_ready
//   out_data           - head word, held stable until popped
//   occupancy          - number of words currently held (0..2)
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign in_ready  = (count != BUF_DEPTH);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign occupancy = count;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: the incoming word lands behind
          // whatever remains after the pop.
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains words from a FIFO with one-cycle read latency and
// presents them on a valid/ready stream, one word per cycle at full rate.
// Ports:
//   rd_clk, reset        - clock, asynchronous active-high reset
//   start, word_limit    - session start pulse (IDLE only) and words per session (0 = unlimited)
//   read_en, read_data, empty - FIFO read side (data valid the cycle after a read)
//   out_valid, out_data, out_ready - downstream stream
//   word_count           - saturating count of downstream transfers this session
//   busy, done           - not-IDLE status, one-cycle session-end pulse
//   seq_err              - sticky "word != previous + 1" flag
// Optional feature: define FIFO_READER_SEQ_CHECK_EN to build the sequence
// checker; otherwise seq_err is tied low.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] word_limit,
  output logic                 read_en,
  input  logic [WIDTH-1:0]     read_data,
  input  logic                 empty,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 seq_err
);

  state_t               state;
  logic [CNT_WIDTH-1:0] limit;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] issued_next;
  logic                 in_flight;
  logic                 buf_ready;
  logic [1:0]           occ;
  logic [1:0]           occ_after;
  logic                 xfer;
  logic                 room;
  logic                 under_limit;

  fifo_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (reset),
    .in_valid  (in_flight),
    .in_ready  (buf_ready),
    .in_data   (read_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occ)
  );

  assign xfer        = out_valid && out_ready;
  // Credit the word leaving this cycle so a full-rate stream keeps issuing
  // one read per cycle; the returning word still always finds a free slot.
  assign occ_after   = occ - {1'b0, xfer};
  assign room        = (occ_after + {1'b0, in_flight}) < BUF_DEPTH;
  assign under_limit = (limit == '0) || (issued < limit);
  assign issued_next = issued + CNT_WIDTH'(1);

  // Combinational so the strobe reacts to empty in the same cycle.
  assign read_en = (state == ST_DRAIN) && !empty && room && under_limit && buf_ready;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      limit      <= '0;
      issued     <= '0;
      in_flight  <= 1'b0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_flight <= read_en;
      done      <= 1'b0;
      if (xfer && (word_count != '1)) word_count <= word_count + CNT_WIDTH'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            limit      <= word_limit;
            issued     <= '0;
            word_count <= '0;
            busy       <= 1'b1;
            state      <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (read_en) begin
            issued <= issued_next;
            if ((limit != '0) && (issued_next == limit)) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Leave as the last buffered word is accepted so done follows it directly.
          if (!in_flight && ((occ == 2'd0) || ((occ == 2'd1) && xfer))) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_SEQ_CHECK_EN
  logic [WIDTH-1:0] prev_word;
  logic             have_prev;
  logic             seq_err_q;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      seq_err_q <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      have_prev <= 1'b0;
      seq_err_q <= 1'b0;
    end else if (xfer) begin
      if (have_prev && (out_data != (prev_word + WIDTH'(1)))) seq_err_q <= 1'b1;
      prev_word <= out_data;
      have_prev <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: self-checking bench for fifo_reader with a behavioural
// one-cycle-latency FIFO and a scoreboard of expected output words.
module tb_fifo_reader;

  localparam int W  = 8;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] word_limit = '0;
  logic          read_en;
  logic [W-1:0]  read_data;
  logic          empty;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b1;
  logic [CW-1:0] word_count;
  logic          busy;
  logic          done;
  logic          seq_err;

  always #5 rd_clk = ~rd_clk;

  fifo_reader #(
    .WIDTH     (W),
    .CNT_WIDTH (CW)
  ) dut (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .start      (start),
    .word_limit (word_limit),
    .read_en    (read_en),
    .read_data  (read_data),
    .empty      (empty),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .seq_err    (seq_err)
  );

  // Behavioural FIFO: data appears the cycle after a read that hits !empty.
  logic [W-1:0] mem [0:255];
  int unsigned  wp = 0;
  int unsigned  rp = 0;
  logic         gap = 1'b0;
  logic         toggle_mode = 1'b0;

  assign empty = (rp == wp) || gap;

  always @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rp        <= wp;
      read_data <= '0;
      gap       <= 1'b0;
    end else begin
      if (read_en && !empty) begin
        read_data <= mem[rp];
        rp        <= rp + 1;
      end
      gap <= toggle_mode ? ~gap : 1'b0;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and monitor
  logic [W-1:0] exp_q [$];
  int           cyc = 0;
  int           xfer_cnt = 0;
  int           done_cnt = 0;
  int           first_xfer_cyc = 0;
  int           last_xfer_cyc = 0;
  int           done_cyc = 0;
  int           ren_empty_viol = 0;
  int           stable_viol = 0;
  int           sess_first;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] exp_w;

  always @(posedge rd_clk) cyc++;

  always @(negedge rd_clk) begin
    if (!reset) begin
      if (read_en && empty) ren_empty_viol++;
      if (prev_stall && out_valid && (out_data !== prev_data)) stable_viol++;
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check_eq("data", out_data, exp_w);
        end
        if (xfer_cnt == sess_first) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic load1(input logic [W-1:0] v);
    mem[wp] = v;
    exp_q.push_back(v);
    wp++;
  endtask

  task automatic load(input int n, input logic [W-1:0] first);
    for (int i = 0; i < n; i++) load1(first + W'(i));
  endtask

  task automatic start_sess(input int lim);
    @(posedge rd_clk); #1;
    word_limit = CW'(lim);
    sess_first = xfer_cnt;
    start = 1'b1;
    @(posedge rd_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge rd_clk); #1;
      if (done_cnt != d0) ok = 1'b1;
    end
    @(posedge rd_clk); #1;
  endtask

  task automatic wait_xfers(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge rd_clk); #1;
      if (xfer_cnt >= target) ok = 1'b1;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_read_en"},    read_en,    0);
    check_eq({tag, "_out_valid"},  out_valid,  0);
    check_eq({tag, "_busy"},       busy,       0);
    check_eq({tag, "_done"},       done,       0);
    check_eq({tag, "_seq_err"},    seq_err,    0);
    check_eq({tag, "_word_count"}, word_count, 0);
    check_eq({tag, "_out_data"},   out_data,   0);
  endtask

  initial begin
    bit ok;
    int s;
    int x0;
    int d0;

    repeat (3) @(posedge rd_clk);
    #2;
    check_idle_outputs("reset");
    @(negedge rd_clk);
    reset = 1'b0;

    // Basic session: 4 words at full rate
    load(4, 8'h01);
    x0 = xfer_cnt;
    start_sess(4);
    s = cyc;
    wait_done(30, ok);
    check_eq("t1_done_seen", ok, 1);
    check_eq("t1_latency", first_xfer_cyc - s, 2);
    check_eq("t1_throughput", last_xfer_cyc - first_xfer_cyc, 3);
    check_eq("t1_done_timing", done_cyc - last_xfer_cyc, 1);
    check_eq("t1_xfers", xfer_cnt - x0, 4);
    check_eq("t1_word_count", word_count, 4);
    check_eq("t1_busy_after", busy, 0);

    // Empty toggling every other cycle
    toggle_mode = 1'b1;
    load(10, 8'h10);
    x0 = xfer_cnt;
    start_sess(10);
    wait_done(100, ok);
    toggle_mode = 1'b0;
    check_eq("t2_done_seen", ok, 1);
    check_eq("t2_read_en_while_empty", ren_empty_viol, 0);
    check_eq("t2_xfers", xfer_cnt - x0, 10);
    check_eq("t2_word_count", word_count, 10);
    check_eq("t2_sb_drained", exp_q.size(), 0);

    // Downstream stall mid-stream
    load(6, 8'h20);
    x0 = xfer_cnt;
    start_sess(6);
    wait_xfers(x0 + 2, 20, ok);
    check_eq("t3_pre_stall", ok, 1);
    out_ready = 1'b0;
    repeat (5) @(posedge rd_clk);
    #1;
    check_eq("t3_stall_read_en", read_en, 0);
    check_eq("t3_stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_done(50, ok);
    check_eq("t3_done_seen", ok, 1);
    check_eq("t3_stable", stable_viol, 0);
    check_eq("t3_xfers", xfer_cnt - x0, 6);
    check_eq("t3_word_count", word_count, 6);

    // Unlimited session
    load(20, 8'h30);
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_sess(0);
    wait_xfers(x0 + 20, 100, ok);
    check_eq("t4_reached_20", ok, 1);
    repeat (5) @(posedge rd_clk);
    #1;
    check_eq("t4_xfers", xfer_cnt - x0, 20);
    check_eq("t4_no_done", done_cnt - d0, 0);
    check_eq("t4_busy", busy, 1);
    check_eq("t4_word_count", word_count, 20);
    reset = 1'b1;
    @(posedge rd_clk); #1;
    exp_q.delete();
    @(negedge rd_clk);
    reset = 1'b0;

    // Reset mid-session
    load(8, 8'h50);
    x0 = xfer_cnt;
    d0 = done_cnt;
    start_sess(8);
    wait_xfers(x0 + 3, 20, ok);
    check_eq("t5_pre_reset", ok, 1);
    @(negedge rd_clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_async");
    exp_q.delete();
    repeat (2) @(posedge rd_clk);
    @(negedge rd_clk);
    reset = 1'b0;
    @(posedge rd_clk); #1;
    check_eq("t5_idle_after_reset", busy, 0);
    check_eq("t5_no_done", done_cnt - d0, 0);
    load(3, 8'h60);
    x0 = xfer_cnt;
    start_sess(3);
    wait_done(30, ok);
    check_eq("t5_restart_done", ok, 1);
    check_eq("t5_restart_xfers", xfer_cnt - x0, 3);
    check_eq("t5_restart_count", word_count, 3);

    // Sequence check: 05,06,08
    load1(8'h05);
    load1(8'h06);
    load1(8'h08);
    start_sess(3);
    wait_done(30, ok);
    check_eq("t6_done_seen", ok, 1);
`ifdef FIFO_READER_SEQ_CHECK_EN
    check_eq("t6_seq_err_set", seq_err, 1);
`else
    check_eq("t6_seq_err_off", seq_err, 0);
`endif
    load1(8'h09);
    start_sess(1);
    check_eq("t6_seq_err_cleared", seq_err, 0);
    wait_done(30, ok);
    check_eq("t6_done2_seen", ok, 1);
    check_eq("t6_seq_err_after", seq_err, 0);
    check_eq("t6_sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
